// File: rtl/cpu_ram_wr_sched.sv
// cpu_ram_wr_sched
//   Write scheduler for the lane-swizzled CPU-side RAM. Two requesters
//   (0 = host load, 1 = compute writeback) each issue a burst command
//   {row, column base, beats-1} followed by a data stream. Bursts are
//   served one at a time, round-robin, onto the single RAM write port.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready  per-requester command handshake
//   i_cmd_row/col/beats_m1   packed per-requester command fields
//   i_dat_valid/o_dat_ready  per-requester data beat handshake
//   i_dat                packed per-requester beats (L lanes each)
//   o_ram_addr           {row, col}, registered
//   o_ram_we             write strobe for all lanes, registered
//   o_ram_data           beat data, registered
//   o_busy               high while a burst is in progress
//   o_grant              current / last granted requester

// One lane word of the registered RAM write data.
module cpu_ram_wr_sched_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     word_q <= '0;
    else if (ld_i) word_q <= d_i;
  end

  assign q_o = word_q;
endmodule

module cpu_ram_wr_sched #(
  parameter int COORD_BITS = 8,
  parameter int SWIZ_BITS  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [1:0]                             i_cmd_valid,
  output logic [1:0]                             o_cmd_ready,
  input  logic [2*COORD_BITS-1:0]                i_cmd_row,
  input  logic [2*COORD_BITS-1:0]                i_cmd_col,
  input  logic [2*COORD_BITS-1:0]                i_cmd_beats_m1,
  input  logic [1:0]                             i_dat_valid,
  output logic [1:0]                             o_dat_ready,
  input  logic [2*(2**SWIZ_BITS)*DATA_WIDTH-1:0] i_dat,
  output logic [2*COORD_BITS-1:0]                o_ram_addr,
  output logic                                   o_ram_we,
  output logic [(2**SWIZ_BITS)*DATA_WIDTH-1:0]   o_ram_data,
  output logic                                   o_busy,
  output logic                                   o_grant
);
  localparam int L  = 2**SWIZ_BITS;
  localparam int LW = L*DATA_WIDTH;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [COORD_BITS-1:0] row_q, row_d;
  logic [COORD_BITS-1:0] col_q, col_d;
  logic [COORD_BITS-1:0] rem_q, rem_d;

  logic                    ram_we_q;
  logic [2*COORD_BITS-1:0] ram_addr_q;

  logic                  win;
  logic                  hs;
  logic [LW-1:0]         beat;
  logic [COORD_BITS-1:0] sel_row, sel_col, sel_beats;
  logic [1:0]            cmd_ready, dat_ready;

  // Round-robin: a lone request wins outright; on a tie the requester
  // that did not go last wins. grant_q doubles as last_grant in IDLE.
  assign win = (i_cmd_valid == 2'b11) ? ~grant_q : i_cmd_valid[1];

  assign sel_row   = win ? i_cmd_row[COORD_BITS +: COORD_BITS]
                         : i_cmd_row[0 +: COORD_BITS];
  assign sel_col   = win ? i_cmd_col[COORD_BITS +: COORD_BITS]
                         : i_cmd_col[0 +: COORD_BITS];
  assign sel_beats = win ? i_cmd_beats_m1[COORD_BITS +: COORD_BITS]
                         : i_cmd_beats_m1[0 +: COORD_BITS];
  assign beat      = grant_q ? i_dat[LW +: LW] : i_dat[0 +: LW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      row_q   <= '0;
      col_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    row_d     = row_q;
    col_d     = col_q;
    rem_d     = rem_q;
    cmd_ready = 2'b00;
    dat_ready = 2'b00;
    hs        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_cmd_valid) begin
          cmd_ready[win] = 1'b1;
          grant_d        = win;
          row_d          = sel_row;
          // Bursts start on a lane-aligned column.
          col_d          = {sel_col[COORD_BITS-1:SWIZ_BITS], {SWIZ_BITS{1'b0}}};
          rem_d          = sel_beats;
          state_d        = BURST;
        end
      end
      BURST: begin
        dat_ready[grant_q] = 1'b1;
        if (i_dat_valid[grant_q]) begin
          hs    = 1'b1;
          // Column wraps modulo 2**COORD_BITS by plain truncation.
          col_d = col_q + COORD_BITS'(L);
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      ram_we_q <= hs;
      if (hs) ram_addr_q <= {row_q, col_q};
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    cpu_ram_wr_sched_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .ld_i  (hs),
      .d_i   (beat[k*DATA_WIDTH +: DATA_WIDTH]),
      .q_o   (o_ram_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_cmd_ready = cmd_ready;
  assign o_dat_ready = dat_ready;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_we    = ram_we_q;
  assign o_busy      = (state_q == BURST);
  assign o_grant     = grant_q;
endmodule
